// File: rtl/maze_mem_arbiter_pkg.sv
// Shared state encoding, geometry and port indices for the maze map memory arbiter.
package maze_pkg;

    localparam int COORD_W = 4;
    localparam int MAP_DIM = 16;

    localparam logic PORT_RAT  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_CLEAR,
        ST_CDONE
    } arb_state_t;

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// One requester's access channel into the maze map arbiter.
interface maze_mem_arbiter_if #(
    parameter int COORD_W = maze_pkg::COORD_W
);
    logic               req;
    logic               lock;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               wr;
    logic               din;
    logic               ack;
    logic               rdata;

    modport master (output req, lock, x, y, wr, din, input ack, rdata);
    modport slave  (input req, lock, x, y, wr, din, output ack, rdata);
endinterface

// File: rtl/maze_mem_arbiter_rr_pick.sv
// Combinational grant selection: locked owner first (within its hold budget), then round-robin.
module maze_rr_pick
    import maze_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    input  logic owner_valid,
    input  logic owner_id,
    input  logic hold_below_max,
    output logic grant_valid,
    output logic grant_id
);
    logic owner_req;
    logic other_req;
    logic ptr_req;
    logic alt_req;

    always_comb begin
        owner_req   = owner_id ? req1 : req0;
        other_req   = owner_id ? req0 : req1;
        ptr_req     = rr_ptr ? req1 : req0;
        alt_req     = rr_ptr ? req0 : req1;
        grant_valid = req0 | req1;
        grant_id    = PORT_RAT;
        // An exhausted owner keeps the memory only when nobody else is waiting.
        if (owner_valid && owner_req && (hold_below_max || !other_req)) begin
            grant_id = owner_id;
        end else if (ptr_req) begin
            grant_id = rr_ptr;
        end else if (alt_req) begin
            grant_id = ~rr_ptr;
        end
    end
endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbiter for the shared 16x16 maze map memory: rat solver (p0) vs host loader (p1), plus map clear.
// Optional per-port grant and clear statistics are built when MAZE_ARB_STATS_EN is defined.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int COORD_W  = maze_pkg::COORD_W,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    maze_mem_arbiter_if.slave  p0,
    maze_mem_arbiter_if.slave  p1,
    input  logic               clr_req,
    output logic               clr_done,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic               mem_din,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               mem_rst_map,
    input  logic               mem_dout
`ifdef MAZE_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1,
    output logic [7:0]         clr_cnt
`endif
);
    // state     | meaning
    // ST_IDLE   | arbitrate: pending clear, then locked owner, then round-robin
    // ST_ACCESS | mem_rd or mem_wr high for one cycle
    // ST_RESP   | ack pulse to the granted port, update rr pointer and lock hold
    // ST_CLEAR  | mem_rst_map high for one cycle
    // ST_CDONE  | clr_done pulse, drop the latched clear and any lock ownership

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t          state;
    logic                gnt;
    logic                wr_q;
    logic                rr_ptr;
    logic                owner_valid;
    logic                owner_id;
    logic                clr_pend;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          ack_q;
    logic [1:0]          rdata_q;

    logic                grant_valid;
    logic                grant_id;
    logic                hold_below_max;
    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic                sel_wr;
    logic                sel_din;
    logic                lock_sel;

    assign p0.ack   = ack_q[PORT_RAT];
    assign p1.ack   = ack_q[PORT_HOST];
    assign p0.rdata = rdata_q[PORT_RAT];
    assign p1.rdata = rdata_q[PORT_HOST];

    assign hold_below_max = hold_cnt < HOLD_W'(MAX_HOLD);

    always_comb begin
        sel_x    = (grant_id == PORT_HOST) ? p1.x   : p0.x;
        sel_y    = (grant_id == PORT_HOST) ? p1.y   : p0.y;
        sel_wr   = (grant_id == PORT_HOST) ? p1.wr  : p0.wr;
        sel_din  = (grant_id == PORT_HOST) ? p1.din : p0.din;
        lock_sel = (gnt == PORT_HOST) ? p1.lock : p0.lock;
    end

    maze_rr_pick u_pick (
        .req0           (p0.req),
        .req1           (p1.req),
        .rr_ptr         (rr_ptr),
        .owner_valid    (owner_valid),
        .owner_id       (owner_id),
        .hold_below_max (hold_below_max),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= PORT_RAT;
            wr_q        <= 1'b0;
            rr_ptr      <= PORT_RAT;
            owner_valid <= 1'b0;
            owner_id    <= PORT_RAT;
            clr_pend    <= 1'b0;
            hold_cnt    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            clr_done    <= 1'b0;
            mem_x       <= '0;
            mem_y       <= '0;
            mem_din     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_rst_map <= 1'b0;
`ifdef MAZE_ARB_STATS_EN
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
            clr_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req || clr_pend) begin
                        mem_rst_map <= 1'b1;
                        state       <= ST_CLEAR;
                    end else if (grant_valid) begin
                        gnt     <= grant_id;
                        mem_x   <= sel_x;
                        mem_y   <= sel_y;
                        mem_din <= sel_din;
                        wr_q    <= sel_wr;
                        mem_rd  <= ~sel_wr;
                        mem_wr  <= sel_wr;
                        if (owner_valid && (grant_id != owner_id)) begin
                            hold_cnt <= '0;
                        end
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_rd     <= 1'b0;
                    mem_wr     <= 1'b0;
                    if (!wr_q) begin
                        rdata_q[gnt] <= mem_dout;
                    end
                    ack_q[gnt] <= 1'b1;
                    if (clr_req) begin
                        clr_pend <= 1'b1;
                    end
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q  <= '0;
                    rr_ptr <= ~gnt;
                    if (lock_sel) begin
                        owner_valid <= 1'b1;
                        owner_id    <= gnt;
                        if (!owner_valid || (owner_id != gnt)) begin
                            hold_cnt <= HOLD_W'(1);
                        end else if (hold_below_max) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        owner_valid <= 1'b0;
                        hold_cnt    <= '0;
                    end
                    if (clr_req) begin
                        clr_pend <= 1'b1;
                    end
`ifdef MAZE_ARB_STATS_EN
                    if (gnt == PORT_RAT) begin
                        if (grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
                    end else begin
                        if (grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
                    end
`endif
                    state  <= ST_IDLE;
                end
                ST_CLEAR: begin
                    mem_rst_map <= 1'b0;
                    clr_done    <= 1'b1;
                    state       <= ST_CDONE;
                end
                ST_CDONE: begin
                    clr_done    <= 1'b0;
                    clr_pend    <= 1'b0;
                    owner_valid <= 1'b0;
                    hold_cnt    <= '0;
`ifdef MAZE_ARB_STATS_EN
                    if (clr_cnt != 8'hFF) clr_cnt <= clr_cnt + 8'd1;
`endif
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed self-checking bench for maze_mem_arbiter with a behavioural 16x16 map memory.
module tb_maze_mem_arbiter;
    import maze_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr_req;
    logic               clr_done;
    logic [COORD_W-1:0] mem_x;
    logic [COORD_W-1:0] mem_y;
    logic               mem_din;
    logic               mem_rd;
    logic               mem_wr;
    logic               mem_rst_map;
    logic               mem_dout;
`ifdef MAZE_ARB_STATS_EN
    logic [15:0]        grant_cnt0;
    logic [15:0]        grant_cnt1;
    logic [7:0]         clr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic map_q [MAP_DIM][MAP_DIM];

    maze_mem_arbiter_if ifc0 ();
    maze_mem_arbiter_if ifc1 ();

    always #5 clk = ~clk;

    maze_mem_arbiter #(.COORD_W(COORD_W), .MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0          (ifc0),
        .p1          (ifc1),
        .clr_req     (clr_req),
        .clr_done    (clr_done),
        .mem_x       (mem_x),
        .mem_y       (mem_y),
        .mem_din     (mem_din),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_rst_map (mem_rst_map),
        .mem_dout    (mem_dout)
`ifdef MAZE_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
        .clr_cnt     (clr_cnt)
`endif
    );

    // Map memory: synchronous write/clear, combinational read.
    always @(posedge clk) begin
        if (mem_rst_map) begin
            for (int i = 0; i < MAP_DIM; i++)
                for (int j = 0; j < MAP_DIM; j++) map_q[i][j] <= 1'b0;
        end else if (mem_wr) begin
            map_q[mem_y][mem_x] <= mem_din;
        end
    end
    assign mem_dout = map_q[mem_y][mem_x];

    task automatic set_port(input int p, input logic [3:0] x, input logic [3:0] y,
                            input logic w, input logic d);
        if (p == 0) begin
            ifc0.req = 1'b1; ifc0.x = x; ifc0.y = y; ifc0.wr = w; ifc0.din = d;
        end else begin
            ifc1.req = 1'b1; ifc1.x = x; ifc1.y = y; ifc1.wr = w; ifc1.din = d;
        end
    endtask

    // Issue one access and return the number of negedges until its ack (-1 on timeout).
    task automatic run_access(input int p, input logic [3:0] x, input logic [3:0] y,
                              input logic w, input logic d, output int lat);
        lat = -1;
        set_port(p, x, y, w, d);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((p == 0 && ifc0.ack === 1'b1) || (p == 1 && ifc1.ack === 1'b1)) begin
                lat = i;
                break;
            end
        end
        ifc0.req = 1'b0;
        ifc1.req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr_req = 1'b0;
        ifc0.req = 0; ifc0.lock = 0; ifc0.x = 0; ifc0.y = 0; ifc0.wr = 0; ifc0.din = 0;
        ifc1.req = 0; ifc1.lock = 0; ifc1.x = 0; ifc1.y = 0; ifc1.wr = 0; ifc1.din = 0;
        for (int i = 0; i < MAP_DIM; i++)
            for (int j = 0; j < MAP_DIM; j++) map_q[i][j] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({ifc0.ack, ifc1.ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {ifc0.ack, ifc1.ack}); end
        n_checks++; if ({ifc0.rdata, ifc1.rdata} !== 2'b00) begin n_fail++; $display("FAIL reset_rdata: got %b expected 00", {ifc0.rdata, ifc1.rdata}); end
        n_checks++; if ({mem_rd, mem_wr, mem_rst_map, clr_done} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {mem_rd, mem_wr, mem_rst_map, clr_done}); end
        n_checks++; if ({mem_x, mem_y, mem_din} !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", {mem_x, mem_y, mem_din}); end
        rst = 1'b0;
    endtask

    task automatic test_write;
        set_port(0, 4'd3, 4'd5, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got %b expected 1", mem_wr); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL wr_no_rd: got %b expected 0", mem_rd); end
        n_checks++; if ({mem_x, mem_y, mem_din} !== {4'd3, 4'd5, 1'b1}) begin n_fail++; $display("FAIL wr_addr: got x=%0d y=%0d din=%b expected x=3 y=5 din=1", mem_x, mem_y, mem_din); end
        n_checks++; if (ifc0.ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b expected 0", ifc0.ack); end
        @(negedge clk);
        n_checks++; if (ifc0.ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_n2: got %b expected 1", ifc0.ack); end
        n_checks++; if ({mem_wr, mem_rd} !== 2'b00) begin n_fail++; $display("FAIL wr_strobe_one_cycle: got %b expected 00", {mem_wr, mem_rd}); end
        ifc0.req = 1'b0;
        @(negedge clk);
        n_checks++; if (ifc0.ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b expected 0", ifc0.ack); end
    endtask

    task automatic test_read;
        set_port(1, 4'd3, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if ({mem_rd, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe: got %b expected 10", {mem_rd, mem_wr}); end
        n_checks++; if ({mem_x, mem_y} !== {4'd3, 4'd5}) begin n_fail++; $display("FAIL rd_addr: got x=%0d y=%0d expected x=3 y=5", mem_x, mem_y); end
        @(negedge clk);
        n_checks++; if (ifc1.ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack_n2: got %b expected 1", ifc1.ack); end
        n_checks++; if (ifc1.rdata !== 1'b1) begin n_fail++; $display("FAIL rd_data1: got %b expected 1", ifc1.rdata); end
        n_checks++; if (ifc0.rdata !== 1'b0) begin n_fail++; $display("FAIL rd_data0_kept: got %b expected 0", ifc0.rdata); end
        ifc1.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int seq [16];
        int n = 0;
        set_port(0, 4'd1, 4'd2, 1'b1, 1'b1);
        set_port(1, 4'd1, 4'd2, 1'b0, 1'b0);
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (ifc0.ack === 1'b1 && n < 16) begin seq[n] = 0; n++; end
            if (ifc1.ack === 1'b1 && n < 16) begin seq[n] = 1; n++; end
        end
        ifc0.req = 1'b0; ifc1.req = 1'b0;
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL rr_ack_count: got %0d expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            n_checks++; if (seq[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, seq[i], i % 2); end
        end
        n_checks++; if (ifc1.rdata !== 1'b1) begin n_fail++; $display("FAIL rr_rdata1: got %b expected 1", ifc1.rdata); end
        @(negedge clk);
    endtask

    task automatic test_lock_hold;
        int seq [16];
        int n = 0;
        ifc0.lock = 1'b1;
        set_port(0, 4'd3, 4'd5, 1'b0, 1'b0);
        set_port(1, 4'd0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 80 && n < 11; c++) begin
            @(negedge clk);
            if (ifc0.ack === 1'b1 && n < 16) begin seq[n] = 0; n++; end
            if (ifc1.ack === 1'b1 && n < 16) begin seq[n] = 1; n++; end
        end
        ifc0.req = 1'b0; ifc1.req = 1'b0; ifc0.lock = 1'b0;
        n_checks++; if (n != 11) begin n_fail++; $display("FAIL lock_ack_count: got %0d expected 11", n); end
        for (int i = 0; i < 11 && i < n; i++) begin
            n_checks++; if (seq[i] != ((i == 8) ? 1 : 0)) begin n_fail++; $display("FAIL lock_order[%0d]: got port %0d expected port %0d", i, seq[i], (i == 8) ? 1 : 0); end
        end
        n_checks++; if ({ifc0.rdata, ifc1.rdata} !== 2'b10) begin n_fail++; $display("FAIL lock_rdata: got %b expected 10", {ifc0.rdata, ifc1.rdata}); end
        @(negedge clk);
    endtask

    task automatic test_clear;
        int n_rst = 0, n_done = 0, first_rst = 0, first_done = 0, lat;
        logic bad_mix = 1'b0;
        logic late_ack = 1'b0;
        set_port(1, 4'd7, 4'd9, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL clr_access_wr: got %b expected 1", mem_wr); end
        clr_req = 1'b1;
        @(negedge clk);
        n_checks++; if (ifc1.ack !== 1'b1) begin n_fail++; $display("FAIL clr_ack_first: got %b expected 1", ifc1.ack); end
        n_checks++; if (mem_rst_map !== 1'b0) begin n_fail++; $display("FAIL clr_not_abort: got %b expected 0", mem_rst_map); end
        ifc1.req = 1'b0;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_rst_map === 1'b1) begin
                n_rst++;
                if (first_rst == 0) first_rst = i;
                if (mem_rd !== 1'b0 || mem_wr !== 1'b0) bad_mix = 1'b1;
            end
            if (clr_done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = i;
            end
            if (ifc0.ack === 1'b1 || ifc1.ack === 1'b1) late_ack = 1'b1;
        end
        n_checks++; if (n_rst != 1) begin n_fail++; $display("FAIL clr_rst_pulses: got %0d expected 1", n_rst); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL clr_done_pulses: got %0d expected 1", n_done); end
        n_checks++; if (first_rst != 1 || first_done != 2) begin n_fail++; $display("FAIL clr_timing: got rst@%0d done@%0d expected rst@1 done@2", first_rst, first_done); end
        n_checks++; if (bad_mix !== 1'b0) begin n_fail++; $display("FAIL clr_strobe_mix: got %b expected 0", bad_mix); end
        n_checks++; if (late_ack !== 1'b0) begin n_fail++; $display("FAIL clr_spurious_ack: got %b expected 0", late_ack); end
        run_access(0, 4'd3, 4'd5, 1'b0, 1'b0, lat);
        n_checks++; if (ifc0.rdata !== 1'b0 || lat != 2) begin n_fail++; $display("FAIL clr_read_35: got rdata=%b lat=%0d expected rdata=0 lat=2", ifc0.rdata, lat); end
        @(negedge clk);
        run_access(1, 4'd7, 4'd9, 1'b0, 1'b0, lat);
        n_checks++; if (ifc1.rdata !== 1'b0 || lat != 2) begin n_fail++; $display("FAIL clr_read_79: got rdata=%b lat=%0d expected rdata=0 lat=2", ifc1.rdata, lat); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int lat;
        logic activity = 1'b0;
        set_port(0, 4'd4, 4'd4, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1 || mem_x !== 4'd4) begin n_fail++; $display("FAIL mrst_access: got wr=%b x=%0d expected wr=1 x=4", mem_wr, mem_x); end
        rst = 1'b1; clr_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; clr_req = 1'b0; ifc0.req = 1'b0;
        n_checks++; if ({ifc0.ack, ifc1.ack, clr_done} !== 3'b000) begin n_fail++; $display("FAIL mrst_pulses: got %b expected 000", {ifc0.ack, ifc1.ack, clr_done}); end
        n_checks++; if ({mem_rd, mem_wr, mem_rst_map} !== 3'b000) begin n_fail++; $display("FAIL mrst_strobes: got %b expected 000", {mem_rd, mem_wr, mem_rst_map}); end
        n_checks++; if ({mem_x, mem_y, mem_din} !== 9'd0) begin n_fail++; $display("FAIL mrst_addr: got %h expected 0", {mem_x, mem_y, mem_din}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc0.ack === 1'b1 || ifc1.ack === 1'b1 || clr_done === 1'b1 || mem_rst_map === 1'b1) activity = 1'b1;
        end
        n_checks++; if (activity !== 1'b0) begin n_fail++; $display("FAIL mrst_quiet: got %b expected 0", activity); end
        // The write strobe was high at the reset edge, so the memory took the write.
        run_access(0, 4'd4, 4'd4, 1'b0, 1'b0, lat);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mrst_reissue_lat: got %0d expected 2", lat); end
        n_checks++; if (ifc0.rdata !== 1'b1) begin n_fail++; $display("FAIL mrst_reissue_data: got %b expected 1", ifc0.rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_lock_hold();
        test_clear();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares the single 16x16 1-bit maze map memory between two requesters:
  - port 0: the rat solver, which reads cells and marks visited cells;
  - port 1: a host map loader/scanner, which writes a new maze and reads it back for display.
- Sits between the requesters and the map memory: it drives X, Y, Din, RD, WR and rst_map and owns all sequencing of that memory.
- Also serialises whole-map clear requests against in-flight accesses.

Parameters:
- COORD_W, 4, width of X and Y coordinates.
- MAX_HOLD, 8, maximum consecutive grants to one locked requester before a forced hand-over.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- lock0 / lock1  in  1  requester asks to keep ownership after the current access.
- x0, y0, x1, y1  in  COORD_W  cell coordinate per requester.
- wr0 / wr1  in  1  1 = write, 0 = read.
- din0 / din1  in  1  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  1  read data, valid in the ack cycle and held until that port's next ack.
- clr_req  in  1  request a whole-map clear.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_x, mem_y  out  COORD_W  to memory X and Y.
- mem_din  out  1  to memory Din.
- mem_rd, mem_wr, mem_rst_map  out  1  to memory RD, WR, rst_map.
- mem_dout  in  1  from memory Dout; combinational read in the cycle mem_rd is high.

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs are 0; rr_ptr=0 (port 0 preferred next).
  - Hold counter is 0; the stored clear request is 0.
- States:
  - IDLE: arbitrate.
  - ACCESS: memory strobes active for one cycle.
  - RESP: ack pulse.
  - CLEAR: mem_rst_map high for one cycle.
  - CDONE: clr_done pulse.
- Arbitration in IDLE, priority highest first:
  1. A pending clear: clr_req, or a clear latched while busy.
  2. The locked owner, if its req is high and hold count < MAX_HOLD.
  3. Round-robin between req0 and req1, starting from rr_ptr.
- On a grant:
  - Register the requester's x, y, wr and din into mem_x, mem_y, mem_din and the wr flag.
  - Go to ACCESS.
- ACCESS:
  - mem_rd = ~wr, mem_wr = wr, for exactly one cycle.
  - On the closing edge, capture mem_dout into rdata<g> if this is a read.
  - Go to RESP.
- RESP:
  - ack<g>=1 for one cycle.
  - rr_ptr becomes the other port.
  - If lock<g> is high, the hold count increments and ownership is kept; otherwise the hold count clears.
  - Return to IDLE.
- Latency: request seen in IDLE at cycle N, ack at N+2; minimum 3-cycle issue interval per access.
- A requester must drop req in the cycle after its ack unless it issues a new access. The arbiter samples req only in IDLE, so a held req re-requests.
- Hold limit: when the hold count reaches MAX_HOLD while the other port requests, the owner is skipped once and the hold count clears. If the other port is idle, the owner continues and the hold count saturates at MAX_HOLD.
- Clear:
  - clr_req arriving in ACCESS or RESP is latched and served at the next IDLE; an in-flight access is never aborted.
  - CLEAR drives mem_rst_map=1, with mem_rd and mem_wr both 0.
  - CDONE pulses clr_done and clears the latch and any lock ownership.
  - Multiple clr_req pulses before service merge into one clear.
- Simultaneous req0 and req1 with no lock: rr_ptr decides.
- mem_rd and mem_wr are never high together; mem_rst_map is never high with either.
- rst asserted mid-operation: the next edge returns to IDLE, no ack or clr_done is generated, and the latched clear is dropped.

Optional Feature:
- Macro: MAZE_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each, saturating, counting acks per port) and clr_cnt (8 bits, saturating).
  - All three reset to 0.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package maze_pkg holds:
  - the state enum: ST_IDLE, ST_ACCESS, ST_RESP, ST_CLEAR, ST_CDONE;
  - COORD_W and MAP_DIM=16;
  - the port index constants PORT_RAT=0 and PORT_HOST=1.
- One sub-module is natural: maze_rr_pick. It is combinational; it takes req0, req1, rr_ptr and the lock/hold qualifiers and returns grant_valid and grant_id.
- The FSM and datapath registers stay in maze_mem_arbiter.

Test Plan:
1. Reset, then req0 write at (3,5) with din=1 -> mem_wr=1 one cycle with mem_x=3, mem_y=5, mem_din=1; ack0 2 cycles after the request; mem_rd stays 0.
2. Memory cell (3,5)=1, then req1 read of (3,5) -> mem_rd pulse; ack1 at N+2 with rdata1=1; rdata0 unchanged.
3. req0 and req1 held high together with no lock, for 6 accesses -> grants alternate 0,1,0,1,0,1; both ports get 3 acks.
4. lock0=1 with req0 and req1 both continuous, MAX_HOLD=8 -> 8 consecutive ack0, then one ack1, then port 0 resumes.
5. clr_req pulsed during ACCESS of a port 1 write -> ack1 completes first, then mem_rst_map one cycle, then clr_done; a subsequent read of any cell returns 0.
6. rst raised in the ACCESS cycle -> next cycle is IDLE with all outputs 0 and no ack; a re-issued request is acked normally (ack at N+2).
